// File: rtl/fifo_uart_tx.sv
// Drains fifo_syn one word at a time and serialises each word as a UART frame:
// one start bit, WIDTH data bits LSB first, one stop bit. tx idles high.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_q,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   shreg_r;
    logic [BAUD_W-1:0]  baud_r;
    logic [BIT_W-1:0]   bit_r;
    logic               baud_last_s;
    logic               bit_last_s;

    // End-of-bit and end-of-word decodes from the registered counters.
    always_comb begin
        baud_last_s = (baud_r == BAUD_LAST);
        bit_last_s  = (bit_r == BIT_LAST);
    end

    // Frame sequencer; fifo_rd, tx and busy are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            shreg_r <= '0;
            baud_r  <= '0;
            bit_r   <= '0;
            fifo_rd <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    baud_r <= '0;
                    bit_r  <= '0;
                    tx     <= 1'b1;
                    if (tx_en && !fifo_empty) begin
                        state_r <= ST_RD;
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        fifo_rd <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_RD: begin
                    // fifo_q is a registered read: it is only valid during WAIT.
                    state_r <= ST_WAIT;
                    fifo_rd <= 1'b0;
                end
                ST_WAIT: begin
                    shreg_r <= fifo_q;
                    tx      <= 1'b0;
                    baud_r  <= '0;
                    state_r <= ST_START;
                end
                ST_START: begin
                    if (baud_last_s) begin
                        baud_r  <= '0;
                        tx      <= shreg_r[0];
                        shreg_r <= shreg_r >> 1;
                        bit_r   <= '0;
                        state_r <= ST_DATA;
                    end else begin
                        baud_r  <= baud_r + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last_s) begin
                        baud_r <= '0;
                        if (bit_last_s) begin
                            bit_r   <= '0;
                            tx      <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            bit_r   <= bit_r + BIT_W'(1);
                            tx      <= shreg_r[0];
                            shreg_r <= shreg_r >> 1;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last_s) begin
                        baud_r  <= '0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        baud_r <= baud_r + BAUD_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    baud_r  <= '0;
                    bit_r   <= '0;
                    fifo_rd <= 1'b0;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural 8-deep registered-read FIFO
// and a UART line monitor that decodes frames at mid-bit.
module tb_fifo_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_en = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_q = 8'h00;
    logic       fifo_rd;
    logic       tx;
    logic       busy;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_q     (fifo_q),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: not tied to the DUT reset, since a popped word stays popped.
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] fmem [8];
    logic [2:0] wp = 3'd0;
    logic [2:0] rp = 3'd0;
    int         fcount = 0;
    assign fifo_empty = (fcount == 0);

    always @(posedge clk) begin
        int inc, dec;
        inc = (wr_en && fcount < 8) ? 1 : 0;
        dec = (fifo_rd === 1'b1 && fcount > 0) ? 1 : 0;
        if (inc == 1) begin
            fmem[wp] <= wr_data;
            wp <= wp + 3'd1;
        end
        if (dec == 1) begin
            fifo_q <= fmem[rp];
            rp <= rp + 3'd1;
        end
        fcount <= fcount + inc - dec;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rd_cnt = 0;
    int bad_pop = 0;
    always @(negedge clk) begin
        if (fifo_rd === 1'b1) begin
            rd_cnt = rd_cnt + 1;
            if (fcount == 0) bad_pop = bad_pop + 1;
        end
    end

    // UART monitor: start detected on the first low sample, bits sampled one cycle into each bit.
    logic [7:0] frames [$];
    int         starts [$];
    int         stop_err = 0;
    bit         mon_active = 1'b0;
    int         mon_start = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        int rel;
        if (!rst_n) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_start  = cyc;
            end
        end else begin
            rel = cyc - mon_start;
            if (rel >= 5 && rel <= 33 && ((rel - 1) % 4) == 0) mon_byte[(rel - 5) / 4] = tx;
            if (rel == 37) begin
                if (tx !== 1'b1) stop_err = stop_err + 1;
                frames.push_back(mon_byte);
                starts.push_back(mon_start);
                mon_active = 1'b0;
            end
        end
    end

    int vec  = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec = vec + 1;
        assert (obs === exp) else begin
            errs = errs + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rd(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo_rd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rd_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames.size() >= n) break;
            @(negedge clk);
        end
        chk("frame_count", frames.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int rd0;
        int bcount;
        bit txlow;
        logic [9:0] fr;
        logic [7:0] exp8;

        // Reset and idle with an empty FIFO
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_no_pop", rd_cnt, 0);

        // Single frame 8'hab with cycle-exact line check
        push(8'hab);
        wait_rd(20);
        bcount = (busy === 1'b1) ? 1 : 0;
        @(negedge clk);
        chk("wait_rd_low", 32'(fifo_rd), 32'd0);
        chk("wait_tx_high", 32'(tx), 32'd1);
        if (busy === 1'b1) bcount++;
        fr = {1'b1, 8'hab, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("ab_tx_%0d", i), 32'(tx), 32'(fr[i / 4]));
            if (busy === 1'b1) bcount++;
        end
        @(negedge clk);
        chk("ab_busy_end", 32'(busy), 32'd0);
        chk("ab_busy_len", bcount, 42);
        repeat (10) @(negedge clk);
        chk("ab_rd_count", rd_cnt, 1);
        chk("ab_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("ab_frames", frames.size(), 1);
        if (frames.size() > 0) chk("ab_decoded", 32'(frames[0]), 32'h0000_00ab);

        // Burst of four words
        frames.delete();
        starts.delete();
        rd0 = rd_cnt;
        push(8'h12);
        push(8'h34);
        push(8'h56);
        push(8'h78);
        wait_frames(4, 250);
        if (frames.size() >= 4) begin
            chk("burst_0", 32'(frames[0]), 32'h12);
            chk("burst_1", 32'(frames[1]), 32'h34);
            chk("burst_2", 32'(frames[2]), 32'h56);
            chk("burst_3", 32'(frames[3]), 32'h78);
            for (int i = 0; i < 3; i++) chk($sformatf("burst_gap_%0d", i), starts[i + 1] - starts[i], 43);
        end
        wait_idle(20);
        chk("burst_rd_count", rd_cnt - rd0, 4);

        // tx_en gating
        frames.delete();
        tx_en = 1'b0;
        rd0 = rd_cnt;
        push(8'hcd);
        push(8'hcc);
        txlow = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) txlow = 1'b1;
        end
        chk("gate_tx_high", 32'(txlow), 32'd0);
        chk("gate_no_pop", rd_cnt - rd0, 0);
        chk("gate_fifo_level", fcount, 2);
        tx_en = 1'b1;
        wait_rd(10);
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
        wait_frames(1, 60);
        repeat (20) @(negedge clk);
        if (frames.size() > 0) chk("gate_cd", 32'(frames[0]), 32'hcd);
        chk("gate_frames", frames.size(), 1);
        chk("gate_empty_low", 32'(fifo_empty), 32'd0);
        chk("gate_rd_count", rd_cnt - rd0, 1);
        chk("gate_busy", 32'(busy), 32'd0);
        tx_en = 1'b1;
        wait_frames(2, 80);
        if (frames.size() > 1) chk("gate_cc", 32'(frames[1]), 32'hcc);
        wait_idle(20);

        // Full drain of eight words
        frames.delete();
        tx_en = 1'b0;
        rd0 = rd_cnt;
        for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
        chk("drain_full", fcount, 8);
        tx_en = 1'b1;
        wait_frames(8, 400);
        for (int i = 0; i < 8; i++) begin
            exp8 = 8'h31 + 8'(i);
            if (frames.size() > i) chk($sformatf("drain_%0d", i), 32'(frames[i]), 32'(exp8));
        end
        repeat (10) @(negedge clk);
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        repeat (50) @(negedge clk);
        chk("drain_rd_count", rd_cnt - rd0, 8);

        // Reset during data bit 3 of 8'hee
        frames.delete();
        tx_en = 1'b0;
        rd0 = rd_cnt;
        push(8'hee);
        push(8'h5a);
        tx_en = 1'b1;
        wait_rd(10);
        @(negedge clk);
        repeat (18) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_frames(1, 80);
        repeat (10) @(negedge clk);
        chk("post_rst_frames", frames.size(), 1);
        if (frames.size() > 0) chk("post_rst_5a", 32'(frames[0]), 32'h5a);
        chk("post_rst_empty", 32'(fifo_empty), 32'd1);
        chk("post_rst_rd_count", rd_cnt - rd0, 2);

        chk("stop_bits", stop_err, 0);
        chk("no_pop_when_empty", bad_pop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
